// File: rtl/up_down_counter_pkg.sv
// up_down_counter_pkg
// Shared types and widths for the up/down counter controller.
//   CNT_W        : counter datapath width
//   PRESC_W      : step prescaler width
//   ctrl_state_t : controller FSM states
//   running_in() : decodes the `running` status from a state and its return flag
package up_down_counter_pkg;

    localparam int unsigned CNT_W   = 32'd4;
    localparam int unsigned PRESC_W = 32'd28;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_LOAD  = 2'd2,
        ST_CLEAR = 2'd3
    } ctrl_state_t;

    // A one-cycle LOAD/CLEAR still reports running when it will return to RUN.
    function automatic logic running_in(input ctrl_state_t s, input logic ret_run);
        logic r;
        case (s)
            ST_RUN:   r = 1'b1;
            ST_LOAD:  r = ret_run;
            ST_CLEAR: r = ret_run;
            default:  r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler
// Counts 0..DIVISOR-1 while `run` is high and flags the terminal count.
//   clk, reset_n : clock, asynchronous active-low reset
//   clr          : synchronous clear of the count to 0 (priority over run)
//   run          : advance enable; the count holds while low
//   tick         : high while running with the count at DIVISOR-1
module tick_prescaler
    import up_down_counter_pkg::*;
#(
    parameter logic [PRESC_W-1:0] DIVISOR = 28'd90000000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic run,
    output logic tick
);

    localparam logic [PRESC_W-1:0] TERM = DIVISOR - 28'd1;

    logic [PRESC_W-1:0] presc_r;

    // Prescaler count: clear, wrap at terminal count, or hold when not running.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_r <= 28'd0;
        end else if (clr) begin
            presc_r <= 28'd0;
        end else if (run) begin
            if (presc_r == TERM) begin
                presc_r <= 28'd0;
            end else begin
                presc_r <= presc_r + 28'd1;
            end
        end else begin
            presc_r <= presc_r;
        end
    end

    assign tick = run && (presc_r == TERM);

endmodule

// File: rtl/up_down_counter_ctrl.sv
// up_down_counter_ctrl
// Sequences the 4-bit up/down counter datapath: a prescaler produces step
// ticks and an FSM (IDLE/RUN/LOAD/CLEAR) arbitrates clear > load > stop > start.
// Inputs : clk, reset_n (async, active-low), start/stop/load_req/clear_req
//          pulses, up_down_sw level, load_data, cnt_value (datapath feedback).
// Outputs: cnt_en/cnt_ld/cnt_clr one-cycle strobes, cnt_up direction,
//          cnt_ld_data, running status. All outputs are registered.
// Optional feature: define UP_DOWN_COUNTER_CTRL_BOUNCE_EN to auto-reverse
// the step direction at MAX_VAL/MIN_VAL instead of letting the datapath wrap.
module up_down_counter_ctrl
    import up_down_counter_pkg::*;
#(
    parameter logic [PRESC_W-1:0] DIVISOR = 28'd90000000,
    parameter logic [CNT_W-1:0]   MAX_VAL = 4'd15,
    parameter logic [CNT_W-1:0]   MIN_VAL = 4'd0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             stop,
    input  logic             up_down_sw,
    input  logic             load_req,
    input  logic [CNT_W-1:0] load_data,
    input  logic             clear_req,
    input  logic [CNT_W-1:0] cnt_value,
    output logic             cnt_en,
    output logic             cnt_up,
    output logic             cnt_ld,
    output logic [CNT_W-1:0] cnt_ld_data,
    output logic             cnt_clr,
    output logic             running
);

    ctrl_state_t state_r, state_next_s;
    logic        ret_run_r, ret_run_next_s;
    logic        dir_r, dir_next_s;
    logic        active_s, clr_acc_s, ld_acc_s, stop_acc_s, start_acc_s;
    logic        run_s, tick_s, step_s;

    // Requests are only heard in IDLE/RUN; strobe states drop everything.
    assign active_s    = (state_r == ST_IDLE) || (state_r == ST_RUN);
    assign clr_acc_s   = active_s && clear_req;
    assign ld_acc_s    = active_s && !clear_req && load_req;
    assign stop_acc_s  = (state_r == ST_RUN) && !clear_req && !load_req && stop;
    assign start_acc_s = (state_r == ST_IDLE) && !clear_req && !load_req && !stop && start;

    // The prescaler keeps advancing on a load/clear acceptance edge (that tick is
    // discarded) so the next step lands a full period after the strobe returns.
    assign run_s  = (state_r == ST_RUN) && !stop_acc_s;
    assign step_s = tick_s && !clr_acc_s && !ld_acc_s;

    tick_prescaler #(
        .DIVISOR (DIVISOR)
    ) u_prescaler (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (start_acc_s),
        .run     (run_s),
        .tick    (tick_s)
    );

    // Next-state and return-flag selection.
    always_comb begin
        state_next_s   = state_r;
        ret_run_next_s = ret_run_r;
        case (state_r)
            ST_IDLE, ST_RUN: begin
                if (clr_acc_s) begin
                    state_next_s   = ST_CLEAR;
                    ret_run_next_s = (state_r == ST_RUN);
                end else if (ld_acc_s) begin
                    state_next_s   = ST_LOAD;
                    ret_run_next_s = (state_r == ST_RUN);
                end else if (stop_acc_s) begin
                    state_next_s   = ST_IDLE;
                end else if (start_acc_s) begin
                    state_next_s   = ST_RUN;
                end else begin
                    state_next_s   = state_r;
                end
            end
            ST_LOAD, ST_CLEAR: begin
                if (ret_run_r) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            default: begin
                state_next_s   = ST_IDLE;
                ret_run_next_s = 1'b0;
            end
        endcase
    end

`ifdef UP_DOWN_COUNTER_CTRL_BOUNCE_EN
    logic sw_prev_r;

    // Limit reversal on an issued step; a switch edge or RUN entry overrides it.
    always_comb begin
        dir_next_s = dir_r;
        if (step_s && dir_r && (cnt_value == MAX_VAL)) begin
            dir_next_s = 1'b0;
        end else if (step_s && !dir_r && (cnt_value == MIN_VAL)) begin
            dir_next_s = 1'b1;
        end else begin
            dir_next_s = dir_r;
        end
        if (start_acc_s || (up_down_sw != sw_prev_r)) begin
            dir_next_s = up_down_sw;
        end else begin
            dir_next_s = dir_next_s;
        end
    end

    // Switch history for edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sw_prev_r <= 1'b1;
        end else begin
            sw_prev_r <= up_down_sw;
        end
    end
`else
    logic unused_s;

    // Without bounce the direction simply tracks the switch.
    always_comb begin
        dir_next_s = up_down_sw;
    end

    assign unused_s = ^{cnt_value, MAX_VAL, MIN_VAL, dir_r};
`endif

    // State, direction and registered strobe outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            ret_run_r   <= 1'b0;
            dir_r       <= 1'b1;
            cnt_en      <= 1'b0;
            cnt_up      <= 1'b0;
            cnt_ld      <= 1'b0;
            cnt_ld_data <= 4'd0;
            cnt_clr     <= 1'b0;
            running     <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            ret_run_r   <= ret_run_next_s;
            dir_r       <= dir_next_s;
            cnt_en      <= step_s;
            cnt_up      <= dir_next_s;
            cnt_ld      <= ld_acc_s;
            cnt_ld_data <= ld_acc_s ? load_data : cnt_ld_data;
            cnt_clr     <= clr_acc_s;
            running     <= running_in(state_next_s, ret_run_next_s);
        end
    end

endmodule

// File: tb/tb_up_down_counter_ctrl.sv
// tb_up_down_counter_ctrl
// Directed bench for up_down_counter_ctrl with DIVISOR=4, a 4-bit datapath
// model closing the cnt_value loop, a cycle-level reference model and
// hand-computed literal checks.
module tb_up_down_counter_ctrl;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0, stop = 1'b0, up_down_sw = 1'b1;
    logic       load_req = 1'b0, clear_req = 1'b0;
    logic [3:0] load_data = 4'd0;
    logic [3:0] cnt_value;
    logic       cnt_en, cnt_up, cnt_ld, cnt_clr, running;
    logic [3:0] cnt_ld_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    up_down_counter_ctrl #(
        .DIVISOR (28'd4),
        .MAX_VAL (4'd15),
        .MIN_VAL (4'd0)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .stop        (stop),
        .up_down_sw  (up_down_sw),
        .load_req    (load_req),
        .load_data   (load_data),
        .clear_req   (clear_req),
        .cnt_value   (cnt_value),
        .cnt_en      (cnt_en),
        .cnt_up      (cnt_up),
        .cnt_ld      (cnt_ld),
        .cnt_ld_data (cnt_ld_data),
        .cnt_clr     (cnt_clr),
        .running     (running)
    );

    // Counter datapath driven by the DUT strobes (wraps naturally in 4 bits).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)     cnt_value <= 4'd0;
        else if (cnt_clr) cnt_value <= 4'd0;
        else if (cnt_ld)  cnt_value <= cnt_ld_data;
        else if (cnt_en)  cnt_value <= cnt_up ? cnt_value + 4'd1 : cnt_value - 4'd1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit         m_run, m_busy, m_dir, m_swp, m_start_now;
    int         m_phase;
    logic [3:0] m_val, m_nv;
    bit         exp_en, exp_up, exp_ld, exp_clr, exp_run;
    bit         n_en, n_ld, n_clr;
    logic [3:0] exp_data;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_run = 0; m_busy = 0; m_phase = 0; m_dir = 1; m_swp = 1; m_val = 4'd0;
            exp_en = 0; exp_up = 0; exp_ld = 0; exp_clr = 0; exp_run = 0; exp_data = 4'd0;
        end else begin
            // what the datapath does with the strobes of the closing cycle
            m_nv = m_val;
            if (exp_clr)     m_nv = 4'd0;
            else if (exp_ld) m_nv = exp_data;
            else if (exp_en) m_nv = exp_up ? m_val + 4'd1 : m_val - 4'd1;
            n_en = 0; n_ld = 0; n_clr = 0; m_start_now = 0;
            if (m_busy) begin
                m_busy = 0;
            end else if (clear_req) begin
                n_clr = 1; m_busy = 1;
                if (m_run) m_phase = (m_phase + 1) % DIV;
            end else if (load_req) begin
                n_ld = 1; m_busy = 1; exp_data = load_data;
                if (m_run) m_phase = (m_phase + 1) % DIV;
            end else if (m_run) begin
                if (stop) m_run = 0;
                else begin
                    n_en = (m_phase == DIV - 1);
                    m_phase = (m_phase + 1) % DIV;
                end
            end else if (start && !stop) begin
                m_run = 1; m_phase = 0; m_start_now = 1;
            end
`ifdef UP_DOWN_COUNTER_CTRL_BOUNCE_EN
            if (n_en && m_dir && m_val == 4'd15)      m_dir = 0;
            else if (n_en && !m_dir && m_val == 4'd0) m_dir = 1;
            if (m_start_now || up_down_sw != m_swp) m_dir = up_down_sw;
            m_swp = up_down_sw;
`else
            m_dir = up_down_sw;
`endif
            exp_en = n_en; exp_ld = n_ld; exp_clr = n_clr;
            exp_up = m_dir; exp_run = m_run; m_val = m_nv;
        end
    end

    // Compare DUT against the model in the middle of every cycle.
    always @(negedge clk) begin
        if (reset_n) begin
            check("m_cnt_en", cnt_en, exp_en);
            check("m_cnt_ld", cnt_ld, exp_ld);
            check("m_cnt_clr", cnt_clr, exp_clr);
            check("m_running", running, exp_run);
            check("m_cnt_value", cnt_value, m_val);
            if (exp_ld) check("m_cnt_ld_data", cnt_ld_data, exp_data);
            if (exp_en) check("m_cnt_up", cnt_up, exp_up);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #2;
        start = 0; stop = 0; load_req = 0; clear_req = 0;
    endtask

    // Wait (bounded) for the next step strobe, then check the resulting value.
    task automatic wait_step(input string name, input logic [3:0] exp_v);
        bit found;
        found = 0;
        for (int i = 0; i < 12 && !found; i++) begin
            @(negedge clk);
            if (cnt_en) found = 1;
        end
        if (!found) check({name, "_timeout"}, 32'd0, 32'd1);
        @(posedge clk);
        #2;
        check(name, cnt_value, exp_v);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] seq_a [4];
        logic [3:0] seq_b [3];
`ifdef UP_DOWN_COUNTER_CTRL_BOUNCE_EN
        seq_a = '{4'd14, 4'd15, 4'd14, 4'd13};
        seq_b = '{4'd0, 4'd1, 4'd2};
`else
        seq_a = '{4'd14, 4'd15, 4'd0, 4'd1};
        seq_b = '{4'd0, 4'd15, 4'd14};
`endif
        #12;
        check("rst_cnt_en", cnt_en, 1'b0);
        check("rst_running", running, 1'b0);
        check("rst_cnt_up", cnt_up, 1'b0);
        check("rst_cnt_ld", cnt_ld, 1'b0);
        check("rst_cnt_clr", cnt_clr, 1'b0);
        reset_n = 1'b1;
        step();

        // start: running next cycle, steps every 4 cycles counting up
        start = 1; step();
        @(negedge clk);
        check("start_running", running, 1'b1);
        repeat (13) step();
        check("count_to_3", cnt_value, 4'd3);

        // load 9 on the prescaler terminal count: tick discarded
        repeat (2) step();
        load_req = 1; load_data = 4'd9; step();
        check("load_strobe", cnt_ld, 1'b1);
        check("load_data", cnt_ld_data, 4'd9);
        check("load_no_en", cnt_en, 1'b0);
        check("load_running", running, 1'b1);
        repeat (5) step();
        check("tick_4_after_load", cnt_en, 1'b1);
        check("loaded_value", cnt_value, 4'd9);
        step();
        check("step_after_load", cnt_value, 4'd10);

        // clear beats load in the same cycle
        clear_req = 1; load_req = 1; load_data = 4'd5; step();
        check("clr_wins", cnt_clr, 1'b1);
        check("clr_no_ld", cnt_ld, 1'b0);
        step();
        check("cleared_value", cnt_value, 4'd0);

        // direction change, stop, idle silence, restart
        up_down_sw = 0;
        repeat (6) step();
        stop = 1; step();
        repeat (10) step();
        check("idle_running", running, 1'b0);
        check("idle_no_en", cnt_en, 1'b0);
        start = 1; step();
        check("restart_running", running, 1'b1);
        repeat (3) step();
        check("restart_no_early_en", cnt_en, 1'b0);
        step();
        check("restart_tick", cnt_en, 1'b1);

        // limit behaviour going up from 13
        up_down_sw = 1; load_req = 1; load_data = 4'd13; step();
        step();
        for (int i = 0; i < 4; i++) wait_step("seq_up", seq_a[i]);

        // limit behaviour going down from 1
        up_down_sw = 0; load_req = 1; load_data = 4'd1; step();
        step();
        for (int i = 0; i < 3; i++) wait_step("seq_down", seq_b[i]);

        // reset in the middle of a CLEAR strobe
        clear_req = 1; step();
        check("clr_before_rst", cnt_clr, 1'b1);
        check("run_before_rst", running, 1'b1);
        #1 reset_n = 1'b0;
        #1;
        check("rst_aborts_clr", cnt_clr, 1'b0);
        check("rst_running_low", running, 1'b0);
        check("rst_no_en", cnt_en, 1'b0);
        step();
        reset_n = 1'b1;
        repeat (6) step();
        check("idle_after_rst", running, 1'b0);
        check("no_en_after_rst", cnt_en, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
